decoder_2to4_stream: RTL

Streaming 2-to-4 binary-to-one-hot decoder with valid/ready handshakes on both sides, a 2-entry output buffer, and per-line saturating hit counters. It is the receive-side counterpart of the 4-to-2 encoder. It turns 2-bit codes back into one-hot line selects for downstream consumers that may stall.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_fifo2.sv | 68 ++++++
 rtl/decoder_2to4_stream.sv | 70 +++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared constants, occupancy encoding and the code-to-line decode used by
// the 2-to-4 streaming decoder.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int LINE_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  // Disabled decodes yield an all-zero word that still travels the stream.
  function automatic logic [LINE_W-1:0] decode(input logic [CODE_W-1:0] code,
                                               input logic              en);
    logic [LINE_W-1:0] word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry FIFO with an explicit EMPTY/ONE/FULL occupancy FSM; dout always
// presents the oldest entry and reads as zero while empty.
module decoder_fifo2
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [LINE_W-1:0] din,
  output logic [LINE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  occ_state_t        state_reg, state_next;
  logic [LINE_W-1:0] head_reg, head_next;
  logic [LINE_W-1:0] tail_reg, tail_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = din;
          state_next = ONE;
        end
      end
      ONE: begin
        // Concurrent push/pop: the incoming word becomes the new head.
        if (push && pop) begin
          head_next = din;
        end else if (push) begin
          tail_next  = din;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign full  = (state_reg == FULL);
  assign empty = (state_reg == EMPTY);
  assign dout  = empty ? '0 : head_reg;

endmodule

// File: rtl/decoder_2to4_stream.sv
// Streaming 2-to-4 one-hot decoder: handshake glue around a 2-entry buffer,
// plus saturating per-line hit counters updated on every retired word.
module decoder_2to4_stream
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_onehot,
  input  logic [1:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_out,
  input  logic              cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LINE_W-1:0] dec_word;
  logic [CNT_W-1:0]  cnt_vec [LINE_W];

  assign dec_word  = decode(in_code, in_en);
  // Ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  decoder_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (dec_word),
    .dout  (out_onehot),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LINE_W; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (pop && out_onehot[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign cnt_out = cnt_vec[cnt_sel];

endmodule
